// File: rtl/pass_ctrl_pkg.sv
// Shared definitions for the pass stream controller: phase encoding,
// GIN stream-select codes and the word-size helper.
package pass_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    LOAD_FILTER  = 3'd1,
    STREAM_IFMAP = 3'd2,
    STREAM_IPSUM = 3'd3,
    DRAIN_OPSUM  = 3'd4,
    DONE         = 3'd5
  } phase_e;

  localparam logic [1:0] SEL_FILTER = 2'd0;
  localparam logic [1:0] SEL_IFMAP  = 2'd1;
  localparam logic [1:0] SEL_IPSUM  = 2'd2;

  function automatic int unsigned bytes_per_word(input int unsigned data_bits);
    return data_bits / 8;
  endfunction

endpackage

// File: rtl/rd_return_fifo.sv
// Read-return buffer: small synchronous FIFO that absorbs GLB read data
// until the GIN network accepts it. Flush drops everything immediately.
module rd_return_fifo #(
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 4,
  parameter int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head_data,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/pass_stream_controller.sv
// Sequences GLB-to-PE traffic for one convolution pass: a single filter
// load, then per output tile an ifmap stream, an ipsum/bias stream and an
// opsum drain. Reads are issued ahead into a return buffer that is sized
// so that outstanding reads can never overflow it.
module pass_stream_controller
  import pass_ctrl_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int CNT_BITS  = 16,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             phase,
  input  logic [ADDR_BITS-1:0]   filter_base,
  input  logic [ADDR_BITS-1:0]   ifmap_base,
  input  logic [ADDR_BITS-1:0]   ipsum_base,
  input  logic [ADDR_BITS-1:0]   opsum_base,
  input  logic [CNT_BITS-1:0]    filter_len,
  input  logic [CNT_BITS-1:0]    ifmap_len,
  input  logic [CNT_BITS-1:0]    ipsum_len,
  input  logic [CNT_BITS-1:0]    opsum_len,
  input  logic [ADDR_BITS-1:0]   ifmap_tile_stride,
  input  logic [ADDR_BITS-1:0]   ipsum_tile_stride,
  input  logic [ADDR_BITS-1:0]   opsum_tile_stride,
  input  logic [CNT_BITS-1:0]    num_tiles,
  output logic                   gin_valid,
  input  logic                   gin_ready,
  output logic [1:0]             gin_sel,
  output logic [DATA_BITS-1:0]   gin_data,
  input  logic                   gon_valid,
  output logic                   gon_ready,
  input  logic [DATA_BITS-1:0]   gon_data,
  output logic [DATA_BITS/8-1:0] glb_re,
  output logic [ADDR_BITS-1:0]   glb_r_addr,
  input  logic [DATA_BITS-1:0]   glb_r_data,
  output logic [DATA_BITS/8-1:0] glb_we,
  output logic [ADDR_BITS-1:0]   glb_w_addr,
  output logic [DATA_BITS-1:0]   glb_w_data
);

  localparam int                 BPW         = bytes_per_word(DATA_BITS);
  localparam int                 CW          = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0]        DEPTH_LIMIT = (CW+1)'(BUF_DEPTH);
  localparam logic [ADDR_BITS-1:0] WORD_STEP = ADDR_BITS'(BPW);
  localparam logic [CNT_BITS-1:0]  CNT_ONE   = CNT_BITS'(1);

  phase_e state, state_next;

  logic [ADDR_BITS-1:0] filter_base_q, ifmap_base_q, ipsum_base_q, opsum_base_q;
  logic [CNT_BITS-1:0]  filter_len_q, ifmap_len_q, ipsum_len_q, opsum_len_q;
  logic [ADDR_BITS-1:0] ifmap_stride_q, ipsum_stride_q, opsum_stride_q;
  logic [CNT_BITS-1:0]  tiles_q;

  logic [CNT_BITS-1:0]  tile_ct, issued, popped, written;
  logic [RD_LAT-1:0]    inflight;
  logic [CW:0]          inflight_cnt;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;

  logic                 read_phase;
  logic [CNT_BITS-1:0]  cur_len;
  logic [ADDR_BITS-1:0] cur_base, cur_stride, phase_addr;
  logic [CNT_BITS-1:0]  word_idx;
  logic [1:0]           cur_sel;
  logic                 issue, push, pop, write, phase_end, last_tile, drain_open;

  rd_return_fifo #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (BUF_DEPTH),
    .CW       (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .push     (push),
    .push_data(glb_r_data),
    .pop      (pop),
    .head_data(gin_data),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Pick the length, base, stride and GIN target that belong to the current phase.
  always_comb begin
    read_phase = 1'b0;
    cur_len    = '0;
    cur_base   = '0;
    cur_stride = '0;
    cur_sel    = SEL_FILTER;
    case (state)
      LOAD_FILTER: begin
        read_phase = 1'b1;
        cur_len    = filter_len_q;
        cur_base   = filter_base_q;
      end
      STREAM_IFMAP: begin
        read_phase = 1'b1;
        cur_len    = ifmap_len_q;
        cur_base   = ifmap_base_q;
        cur_stride = ifmap_stride_q;
        cur_sel    = SEL_IFMAP;
      end
      STREAM_IPSUM: begin
        read_phase = 1'b1;
        cur_len    = ipsum_len_q;
        cur_base   = ipsum_base_q;
        cur_stride = ipsum_stride_q;
        cur_sel    = SEL_IPSUM;
      end
      DRAIN_OPSUM: begin
        cur_len    = opsum_len_q;
        cur_base   = opsum_base_q;
        cur_stride = opsum_stride_q;
      end
      default: ;
    endcase
  end

  // Count reads still travelling through the GLB pipeline.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + (CW+1)'(inflight[i]);
    end
  end

  assign word_idx   = read_phase ? issued : written;
  assign phase_addr = cur_base + ADDR_BITS'(tile_ct) * cur_stride + ADDR_BITS'(word_idx) * WORD_STEP;

  assign issue      = read_phase && !abort && (issued != cur_len) &&
                      ((inflight_cnt + (CW+1)'(fifo_count)) < DEPTH_LIMIT);
  assign push       = inflight[RD_LAT-1];
  assign gin_valid  = !fifo_empty;
  assign pop        = gin_valid && gin_ready;
  assign drain_open = (state == DRAIN_OPSUM) && !abort && (written != cur_len);
  assign write      = drain_open && gon_valid;
  assign last_tile  = (tile_ct == tiles_q - CNT_ONE);

  assign phase_end  = (read_phase && ((cur_len == '0) || (pop && (popped == cur_len - CNT_ONE)))) ||
                      ((state == DRAIN_OPSUM) && ((cur_len == '0) || (write && (written == cur_len - CNT_ONE))));

  assign gon_ready  = drain_open;
  assign gin_sel    = cur_sel;
  assign glb_re     = issue ? '1 : '0;
  assign glb_r_addr = issue ? phase_addr : '0;
  assign glb_we     = write ? '1 : '0;
  assign glb_w_addr = write ? phase_addr : '0;
  assign glb_w_data = gon_data;
  assign phase      = state;

  // Phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Phase sequencing plus status flags; abort overrides everything, including start.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:         if (start)     state_next = LOAD_FILTER;
        LOAD_FILTER:  if (phase_end) state_next = STREAM_IFMAP;
        STREAM_IFMAP: if (phase_end) state_next = STREAM_IPSUM;
        STREAM_IPSUM: if (phase_end) state_next = DRAIN_OPSUM;
        DRAIN_OPSUM:  if (phase_end) state_next = last_tile ? DONE : STREAM_IFMAP;
        DONE:         state_next = IDLE;
        default:      state_next = IDLE;
      endcase
    end
  end

  // Configuration capture at start and the per-phase/per-tile word counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filter_base_q  <= '0;
      ifmap_base_q   <= '0;
      ipsum_base_q   <= '0;
      opsum_base_q   <= '0;
      filter_len_q   <= '0;
      ifmap_len_q    <= '0;
      ipsum_len_q    <= '0;
      opsum_len_q    <= '0;
      ifmap_stride_q <= '0;
      ipsum_stride_q <= '0;
      opsum_stride_q <= '0;
      tiles_q        <= '0;
      tile_ct        <= '0;
      issued         <= '0;
      popped         <= '0;
      written        <= '0;
    end else begin
      if ((state == IDLE) && start && !abort) begin
        filter_base_q  <= filter_base;
        ifmap_base_q   <= ifmap_base;
        ipsum_base_q   <= ipsum_base;
        opsum_base_q   <= opsum_base;
        filter_len_q   <= filter_len;
        ifmap_len_q    <= ifmap_len;
        ipsum_len_q    <= ipsum_len;
        opsum_len_q    <= opsum_len;
        ifmap_stride_q <= ifmap_tile_stride;
        ipsum_stride_q <= ipsum_tile_stride;
        opsum_stride_q <= opsum_tile_stride;
        tiles_q        <= (num_tiles == '0) ? CNT_ONE : num_tiles;
        tile_ct        <= '0;
      end
      if (abort || phase_end) begin
        issued  <= '0;
        popped  <= '0;
        written <= '0;
      end else begin
        if (issue) issued  <= issued + CNT_ONE;
        if (pop)   popped  <= popped + CNT_ONE;
        if (write) written <= written + CNT_ONE;
      end
      if (!abort && (state == DRAIN_OPSUM) && phase_end && !last_tile) begin
        tile_ct <= tile_ct + CNT_ONE;
      end
    end
  end

  // Shift register marking which cycles carry returning read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       inflight <= '0;
    else if (abort) inflight <= '0;
    else            inflight <= RD_LAT'({inflight, issue});
  end

endmodule

// File: tb/tb_pass_stream_controller.sv
// Self-checking bench for pass_stream_controller with a GLB read-latency
// model and a transaction-level reference built from the configuration.
module tb_pass_stream_controller;

  localparam int DB    = 32;
  localparam int AB    = 32;
  localparam int CB    = 16;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          start, abort;
  logic          busy, done;
  logic [2:0]    phase;
  logic [AB-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
  logic [CB-1:0] filter_len, ifmap_len, ipsum_len, opsum_len;
  logic [AB-1:0] ifmap_tile_stride, ipsum_tile_stride, opsum_tile_stride;
  logic [CB-1:0] num_tiles;
  logic          gin_valid, gin_ready;
  logic [1:0]    gin_sel;
  logic [DB-1:0] gin_data;
  logic          gon_valid, gon_ready;
  logic [DB-1:0] gon_data;
  logic [3:0]    glb_re, glb_we;
  logic [AB-1:0] glb_r_addr, glb_w_addr;
  logic [DB-1:0] glb_r_data, glb_w_data;

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;
  int ipsum_cycles = 0;
  int outstanding = 0;

  logic [AB-1:0] exp_rd[$];
  logic [33:0]   exp_gin[$];
  logic [AB-1:0] exp_wr[$];
  logic [33:0]   mon_e;

  logic [AB-1:0] rd_pipe_a [LAT];

  pass_stream_controller #(
    .DATA_BITS(DB), .ADDR_BITS(AB), .CNT_BITS(CB), .RD_LAT(LAT), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .phase(phase),
    .filter_base(filter_base), .ifmap_base(ifmap_base), .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .filter_len(filter_len), .ifmap_len(ifmap_len), .ipsum_len(ipsum_len), .opsum_len(opsum_len),
    .ifmap_tile_stride(ifmap_tile_stride), .ipsum_tile_stride(ipsum_tile_stride),
    .opsum_tile_stride(opsum_tile_stride), .num_tiles(num_tiles),
    .gin_valid(gin_valid), .gin_ready(gin_ready), .gin_sel(gin_sel), .gin_data(gin_data),
    .gon_valid(gon_valid), .gon_ready(gon_ready), .gon_data(gon_data),
    .glb_re(glb_re), .glb_r_addr(glb_r_addr), .glb_r_data(glb_r_data),
    .glb_we(glb_we), .glb_w_addr(glb_w_addr), .glb_w_data(glb_w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GLB contents: every address holds a value derived from the address itself.
  function automatic logic [DB-1:0] glbWord(input logic [AB-1:0] a);
    return (a * 32'h0001_0003) + 32'h0000_1357;
  endfunction

  // GLB read port: data for a request appears LAT cycles after it is issued.
  always @(posedge clk) begin
    rd_pipe_a[0] <= glb_r_addr;
    for (int i = 1; i < LAT; i++) rd_pipe_a[i] <= rd_pipe_a[i-1];
  end
  assign glb_r_data = glbWord(rd_pipe_a[LAT-1]);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference transaction lists: read addresses, GIN beats and opsum write addresses.
  task automatic buildModel();
    int tiles;
    logic [AB-1:0] a;
    exp_rd.delete(); exp_gin.delete(); exp_wr.delete();
    tiles = (num_tiles == 0) ? 1 : int'(num_tiles);
    for (int i = 0; i < int'(filter_len); i++) begin
      a = filter_base + 32'(i) * 4;
      exp_rd.push_back(a); exp_gin.push_back({2'd0, glbWord(a)});
    end
    for (int t = 0; t < tiles; t++) begin
      for (int i = 0; i < int'(ifmap_len); i++) begin
        a = ifmap_base + 32'(t) * ifmap_tile_stride + 32'(i) * 4;
        exp_rd.push_back(a); exp_gin.push_back({2'd1, glbWord(a)});
      end
      for (int i = 0; i < int'(ipsum_len); i++) begin
        a = ipsum_base + 32'(t) * ipsum_tile_stride + 32'(i) * 4;
        exp_rd.push_back(a); exp_gin.push_back({2'd2, glbWord(a)});
      end
      for (int i = 0; i < int'(opsum_len); i++) begin
        exp_wr.push_back(opsum_base + 32'(t) * opsum_tile_stride + 32'(i) * 4);
      end
    end
  endtask

  // Transaction monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (phase == 3'd3) ipsum_cycles++;
      if (done) done_seen++;
      if (glb_re != 4'h0) begin
        checkOutput("glb_re_mask", 64'(glb_re), 64'hF);
        checkOutput("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) checkOutput("rd_addr", 64'(glb_r_addr), 64'(exp_rd.pop_front()));
        outstanding++;
      end
      if (gin_valid && gin_ready) begin
        checkOutput("gin_expected", 64'(exp_gin.size() != 0), 64'd1);
        if (exp_gin.size() != 0) begin
          mon_e = exp_gin.pop_front();
          checkOutput("gin_sel", 64'(gin_sel), 64'(mon_e[33:32]));
          checkOutput("gin_data", 64'(gin_data), 64'(mon_e[31:0]));
        end
        outstanding--;
      end
      if (glb_re != 4'h0) checkOutput("outstanding_bound", 64'(outstanding <= DEPTH), 64'd1);
      if (glb_we != 4'h0) begin
        checkOutput("glb_we_mask", 64'(glb_we), 64'hF);
        checkOutput("wr_handshake", 64'(gon_valid && gon_ready), 64'd1);
        checkOutput("wr_data", 64'(glb_w_data), 64'(gon_data));
        checkOutput("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) checkOutput("wr_addr", 64'(glb_w_addr), 64'(exp_wr.pop_front()));
      end
    end
  end

  task automatic startRun(input int fl, il, pl, ol, nt, input logic [AB-1:0] ifs, ips, ops);
    filter_base = $urandom; ifmap_base = $urandom; ipsum_base = $urandom; opsum_base = $urandom;
    filter_len = CB'(fl); ifmap_len = CB'(il); ipsum_len = CB'(pl); opsum_len = CB'(ol);
    ifmap_tile_stride = ifs; ipsum_tile_stride = ips; opsum_tile_stride = ops;
    num_tiles = CB'(nt);
    buildModel();
    done_seen = 0; ipsum_cycles = 0; outstanding = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    filter_base = $urandom; ifmap_base = $urandom; opsum_base = $urandom;
    filter_len = CB'($urandom); opsum_tile_stride = $urandom; num_tiles = CB'($urandom);
  endtask

  // mode 0: always ready; 1: random handshakes and stray start pulses; 2: GIN stalled 10 cycles.
  task automatic applyStimulus(input int fl, il, pl, ol, nt, input logic [AB-1:0] ifs, ips, ops, input int mode);
    startRun(fl, il, pl, ol, nt, ifs, ips, ops);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done_seen != 0) break;
      gin_ready = (mode == 0) ? 1'b1 : (mode == 2) ? !(cyc >= 4 && cyc < 14) : ($urandom % 4 != 0);
      gon_valid = (mode == 0) ? 1'b1 : 1'($urandom % 2);
      gon_data  = $urandom;
      start     = (mode == 1) && busy && ($urandom % 16 == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; gin_ready = 1'b1; gon_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("done_pulses", 64'(done_seen), 64'd1);
    checkOutput("idle_after_done", 64'(busy), 64'd0);
    checkOutput("rd_left", 64'(exp_rd.size()), 64'd0);
    checkOutput("gin_left", 64'(exp_gin.size()), 64'd0);
    checkOutput("wr_left", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    gin_ready = 1'b1; gon_valid = 1'b0; gon_data = '0;
    filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
    filter_len = '0; ifmap_len = '0; ipsum_len = '0; opsum_len = '0;
    ifmap_tile_stride = '0; ipsum_tile_stride = '0; opsum_tile_stride = '0; num_tiles = '0;
    repeat (2) @(posedge clk); #1;

    checkOutput("rst_phase", 64'(phase), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_gin_valid", 64'(gin_valid), 64'd0);
    checkOutput("rst_gon_ready", 64'(gon_ready), 64'd0);
    checkOutput("rst_glb_re", 64'(glb_re), 64'd0);
    checkOutput("rst_glb_we", 64'(glb_we), 64'd0);
    checkOutput("rst_r_addr", 64'(glb_r_addr), 64'd0);
    checkOutput("rst_w_addr", 64'(glb_w_addr), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic single tile");
    applyStimulus(4, 6, 2, 2, 1, $urandom, $urandom, $urandom, 0);

    $display("[TB] backpressure");
    applyStimulus(8, 5, 3, 3, 1, $urandom, $urandom, $urandom, 2);

    $display("[TB] tile loop");
    applyStimulus(3, 4, 2, 2, 3, $urandom, 32'h0, 32'h40, 1);

    $display("[TB] zero-length ipsum, zero tiles");
    applyStimulus(2, 3, 0, 2, 0, $urandom, $urandom, $urandom, 1);
    checkOutput("ipsum_one_cycle", 64'(ipsum_cycles), 64'd1);

    $display("[TB] abort during ifmap");
    startRun(2, 6, 2, 2, 1, $urandom, $urandom, $urandom);
    gin_ready = 1'b1; gon_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && phase != 3'd2; cyc++) begin @(posedge clk); #1; end
    checkOutput("abort_reach_ifmap", 64'(phase), 64'd2);
    repeat (2) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_phase", 64'(phase), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_gin_valid", 64'(gin_valid), 64'd0);
    exp_rd.delete(); exp_gin.delete(); exp_wr.delete(); outstanding = 0;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("abort_gin_quiet", 64'(gin_valid), 64'd0);
    end
    checkOutput("abort_no_done", 64'(done_seen), 64'd0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checkOutput("abort_beats_start", 64'(busy), 64'd0);
    applyStimulus(3, 2, 2, 2, 1, $urandom, $urandom, $urandom, 0);

    $display("[TB] reset mid-drain");
    startRun(1, 1, 1, 6, 1, $urandom, $urandom, $urandom);
    gin_ready = 1'b1; gon_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && phase != 3'd4; cyc++) begin @(posedge clk); #1; end
    checkOutput("drain_reached", 64'(phase), 64'd4);
    checkOutput("drain_ready", 64'(gon_ready), 64'd1);
    gon_valid = 1'b1; gon_data = $urandom;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_phase", 64'(phase), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_gon_ready", 64'(gon_ready), 64'd0);
    checkOutput("arst_glb_we", 64'(glb_we), 64'd0);
    checkOutput("arst_w_addr", 64'(glb_w_addr), 64'd0);
    checkOutput("arst_glb_re", 64'(glb_re), 64'd0);
    checkOutput("arst_gin_valid", 64'(gin_valid), 64'd0);
    exp_rd.delete(); exp_gin.delete(); exp_wr.delete(); outstanding = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      checkOutput("post_rst_no_we", 64'(glb_we), 64'd0);
    end
    gon_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
